// File: rtl/shift_seq_ctrl.sv
// Multicycle sequencer for an external 64-bit shifter: splits a shift into steps of at most STEP_MAX bits.
// Optional macro SHIFT_SINGLE_CYCLE_EN issues the whole amount in a single step.
module shift_seq_ctrl #(
    parameter int WIDTH    = 64,
    parameter int AMT_W    = 6,
    parameter int STEP_MAX = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs1,
    input  logic [AMT_W-1:0] shamt,
    output logic             busy,
    output logic             done,
    output logic             reg_wr,
    output logic [WIDTH-1:0] result,
    output logic [1:0]       shift_sel,
    output logic [AMT_W-1:0] shift_n,
    output logic [WIDTH-1:0] shift_in,
    input  logic [WIDTH-1:0] shift_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0]       OP_PASS  = 2'b11;
    localparam logic [AMT_W-1:0] STEP_LIM = AMT_W'(STEP_MAX);

    state_t           state_r;
    state_t           next_state_s;
    logic [1:0]       op_r;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] acc_next_s;
    logic [AMT_W-1:0] rem_r;
    logic [AMT_W-1:0] rem_next_s;
    logic [AMT_W-1:0] step_n_s;

    // Amount issued to the shifter this step
    always_comb begin
`ifdef SHIFT_SINGLE_CYCLE_EN
        step_n_s = rem_r;
`else
        if (rem_r < STEP_LIM) begin
            step_n_s = rem_r;
        end else begin
            step_n_s = STEP_LIM;
        end
`endif
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and next accumulator/remaining-amount logic
    always_comb begin
        next_state_s = state_r;
        acc_next_s   = acc_r;
        rem_next_s   = rem_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    acc_next_s = rs1;
                    rem_next_s = shamt;
                    if ((shamt == {AMT_W{1'b0}}) || (op == OP_PASS)) begin
                        next_state_s = DONE;
                    end else begin
                        next_state_s = STEP;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            STEP: begin
                acc_next_s = shift_out;
                rem_next_s = rem_r - step_n_s;
                if (rem_next_s == {AMT_W{1'b0}}) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = STEP;
                end
            end
            DONE: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Datapath registers; result captures the final value on entry to DONE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_r  <= {WIDTH{1'b0}};
            rem_r  <= {AMT_W{1'b0}};
            op_r   <= 2'b00;
            result <= {WIDTH{1'b0}};
        end else begin
            acc_r <= acc_next_s;
            rem_r <= rem_next_s;
            if ((state_r == IDLE) && start) begin
                op_r <= op;
            end else begin
                op_r <= op_r;
            end
            if (next_state_s == DONE) begin
                result <= acc_next_s;
            end else begin
                result <= result;
            end
        end
    end

    // Outputs decoded from state; the shifter idles in pass mode outside STEP
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        reg_wr    = 1'b0;
        shift_sel = OP_PASS;
        shift_n   = {AMT_W{1'b0}};
        shift_in  = acc_r;
        case (state_r)
            IDLE: begin
                busy = 1'b0;
            end
            STEP: begin
                busy      = 1'b1;
                shift_sel = op_r;
                shift_n   = step_n_s;
            end
            DONE: begin
                busy   = 1'b1;
                done   = 1'b1;
                reg_wr = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl with a behavioural shifter and a whole-shift reference model.
module tb_shift_seq_ctrl;

    localparam int WIDTH    = 64;
    localparam int AMT_W    = 6;
    localparam int STEP_MAX = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] rs1;
    logic [AMT_W-1:0] shamt;
    logic             busy;
    logic             done;
    logic             reg_wr;
    logic [WIDTH-1:0] result;
    logic [1:0]       shift_sel;
    logic [AMT_W-1:0] shift_n;
    logic [WIDTH-1:0] shift_in;
    logic [WIDTH-1:0] shift_out;

    int               total = 0;
    int               bad   = 0;
    logic [WIDTH-1:0] last_result;

    shift_seq_ctrl #(.WIDTH(WIDTH), .AMT_W(AMT_W), .STEP_MAX(STEP_MAX)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .rs1(rs1), .shamt(shamt),
        .busy(busy), .done(done), .reg_wr(reg_wr), .result(result),
        .shift_sel(shift_sel), .shift_n(shift_n), .shift_in(shift_in), .shift_out(shift_out)
    );

    always #5 clk = ~clk;

    // Behavioural 64-bit combinational shifter the sequencer drives
    always_comb begin
        case (shift_sel)
            2'b00:   shift_out = shift_in << shift_n;
            2'b01:   shift_out = shift_in >> shift_n;
            2'b10:   shift_out = $unsigned($signed(shift_in) >>> shift_n);
            default: shift_out = shift_in;
        endcase
    end

    function automatic logic [WIDTH-1:0] ref_shift(input logic [1:0] o, input logic [WIDTH-1:0] a,
                                                   input int n);
        case (o)
            2'b00:   return a << n;
            2'b01:   return a >> n;
            2'b10:   return $unsigned($signed(a) >>> n);
            default: return a;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [WIDTH-1:0] a, input int n, input bit poke);
        int               steps[$];
        int               r;
        int               k;
        logic [WIDTH-1:0] exp_res;
        bit               fin;
        exp_res = ref_shift(o, a, n);
        r = (o == 2'b11) ? 0 : n;
        while (r > 0) begin
`ifdef SHIFT_SINGLE_CYCLE_EN
            steps.push_back(r);
            r = 0;
`else
            steps.push_back((r < STEP_MAX) ? r : STEP_MAX);
            r = r - ((r < STEP_MAX) ? r : STEP_MAX);
`endif
        end
        k = steps.size();
        @(negedge clk);
        op = o; rs1 = a; shamt = AMT_W'(n); start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; op = 2'($urandom); rs1 = {$urandom, $urandom}; shamt = AMT_W'($urandom);
        fin = 1'b0;
        for (int c = 1; c <= 100 && !fin; c++) begin
            @(negedge clk);
            check("busy", 64'(busy), 64'(1));
            check("done", 64'(done), 64'(c == k + 1));
            check("reg_wr", 64'(reg_wr), 64'(c == k + 1));
            if (c <= k) begin
                check("shift_n", 64'(shift_n), 64'(steps[c-1]));
                check("shift_sel_step", 64'(shift_sel), 64'(o));
                check("result_held", result, last_result);
            end else begin
                check("result", result, exp_res);
                check("shift_sel_done", 64'(shift_sel), 64'(2'b11));
                fin = 1'b1;
            end
            // Poke start while busy (first STEP and the DONE cycle); it must be ignored
            if (c == k + 1 || (poke && c == 1)) begin
                start = 1'b1; rs1 = 64'hFF; shamt = 6'd5; op = 2'b00;
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        check("idle_busy", 64'(busy), 64'(0));
        check("idle_done", 64'(done), 64'(0));
        check("idle_result", result, exp_res);
        start = 1'b0;
        last_result = exp_res;
    endtask

    initial begin
        logic [1:0] ro;
        int         rn;
        reset = 1'b1; start = 1'b0; op = 2'b00; rs1 = '0; shamt = '0;
        #1;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_reg_wr", 64'(reg_wr), 64'(0));
        check("rst_result", result, 64'h0);
        check("rst_shift_sel", 64'(shift_sel), 64'(2'b11));
        check("rst_shift_n", 64'(shift_n), 64'(0));
        check("rst_shift_in", shift_in, 64'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        last_result = 64'h0;

        run_op(2'b00, 64'h1, 40, 1'b0);
        check("sll40", result, 64'h0000_0100_0000_0000);
        run_op(2'b10, 64'h8000_0000_0000_0000, 63, 1'b0);
        check("sra63", result, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op(2'b01, 64'h8000_0000_0000_0000, 63, 1'b0);
        check("srl63", result, 64'h0000_0000_0000_0001);
        run_op(2'b00, 64'hDEAD, 0, 1'b0);
        check("sll0", result, 64'hDEAD);
        run_op(2'b11, 64'h1234_5678_9ABC_DEF0, 17, 1'b0);
        run_op(2'b10, 64'hF000_0000_0000_0000, 60, 1'b0);
        check("sra60", result, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op(2'b00, 64'h1, 40, 1'b1);
        check("sll40_poked", result, 64'h0000_0100_0000_0000);

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0:       rn = 0;
                1:       rn = 63;
                2:       rn = STEP_MAX;
                3:       rn = STEP_MAX + 1;
                default: rn = $urandom_range(0, 63);
            endcase
            run_op(ro, {$urandom, $urandom}, rn, 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a stepped shift
        @(negedge clk);
        op = 2'b00; rs1 = 64'h1; shamt = 6'd40; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_done", 64'(done), 64'(0));
        check("mid_rst_result", result, 64'h0);
        check("mid_rst_sel", 64'(shift_sel), 64'(2'b11));
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("post_rst_done", 64'(done), 64'(0));
            check("post_rst_busy", 64'(busy), 64'(0));
        end
        last_result = 64'h0;
        run_op(2'b01, 64'hFFFF_0000_FFFF_0000, 33, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
